// File: rtl/pe_acc_pkg.sv
// Shared definitions for the pe_acc per-lane accumulator: default sizes,
// control state encoding and the group-framing check.
package pe_acc_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_DATA_COPIES = 32;
    localparam int DEF_ACC_WIDTH   = 32;
    localparam int DEF_CNT_WIDTH   = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

    // A group must open with i_first exactly when no partial sum is held.
    function automatic logic seq_error(input state_e st, input logic first);
        if (st == ST_IDLE) begin
            return ~first;
        end else begin
            return first;
        end
    endfunction

endpackage

// File: rtl/pe_acc_lane.sv
// One accumulator lane: sign-extends the product, selects start/add, optionally
// saturates (PE_ACC_SAT_EN), and holds the running sum plus the result register.
module pe_acc_lane
    import pe_acc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_beat,
    input  logic                    i_start,
    input  logic                    i_load,
    input  logic [2*DATA_WIDTH-1:0] i_product,
    output logic [ACC_WIDTH-1:0]    o_result
`ifdef PE_ACC_SAT_EN
  , output logic                    o_sat_next
`endif
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int EXT_W  = ACC_WIDTH - PROD_W;

    logic [ACC_WIDTH-1:0] prod_ext_s;
    logic [ACC_WIDTH-1:0] add_s;
    logic [ACC_WIDTH-1:0] acc_next_s;
    logic [ACC_WIDTH-1:0] acc_r;
    logic [ACC_WIDTH-1:0] res_r;

    if (EXT_W > 0) begin : g_ext
        assign prod_ext_s = {{EXT_W{i_product[PROD_W-1]}}, i_product};
    end else begin : g_noext
        assign prod_ext_s = i_product;
    end

`ifdef PE_ACC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH:0] sum_wide_s;
    logic               ovf_s;
    logic               sat_next_s;
    logic               sat_r;

    // One guard bit detects signed overflow; clamp toward the sign of the true sum.
    always_comb begin
        sum_wide_s = {acc_r[ACC_WIDTH-1], acc_r} + {prod_ext_s[ACC_WIDTH-1], prod_ext_s};
        ovf_s      = sum_wide_s[ACC_WIDTH] ^ sum_wide_s[ACC_WIDTH-1];
        if (!ovf_s) begin
            add_s = sum_wide_s[ACC_WIDTH-1:0];
        end else if (sum_wide_s[ACC_WIDTH]) begin
            add_s = ACC_MIN;
        end else begin
            add_s = ACC_MAX;
        end
        if (i_start) begin
            sat_next_s = 1'b0;
        end else begin
            sat_next_s = sat_r | ovf_s;
        end
    end

    // Sticky per-group saturation marker, restarted with each group.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sat_r <= 1'b0;
        end else if (i_beat) begin
            sat_r <= sat_next_s;
        end
    end

    assign o_sat_next = sat_next_s;
`else
    // Plain two's-complement add, wrapping modulo 2^ACC_WIDTH.
    always_comb begin
        add_s = acc_r + prod_ext_s;
    end
`endif

    // A starting beat discards any partial sum.
    always_comb begin
        if (i_start) begin
            acc_next_s = prod_ext_s;
        end else begin
            acc_next_s = add_s;
        end
    end

    // Running sum and the result register presented downstream.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_r <= '0;
            res_r <= '0;
        end else begin
            if (i_beat) begin
                acc_r <= acc_next_s;
            end
            if (i_load) begin
                res_r <= acc_next_s;
            end
        end
    end

    assign o_result = res_r;

endmodule

// File: rtl/pe_acc.sv
// Per-lane signed dot-product accumulator with valid/ready result port.
// Optional feature macro: PE_ACC_SAT_EN (saturating lanes plus o_sat output).
module pe_acc
    import pe_acc_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DATA_COPIES = DEF_DATA_COPIES,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_valid,
    output logic                                o_in_ready,
    input  logic                                i_first,
    input  logic                                i_last,
    input  logic [DATA_COPIES*2*DATA_WIDTH-1:0] i_mul_result,
    output logic                                o_valid,
    input  logic                                i_out_ready,
    output logic [DATA_COPIES*ACC_WIDTH-1:0]    o_acc_result,
    output logic [CNT_WIDTH-1:0]                o_beat_cnt,
    output logic                                o_seq_err
`ifdef PE_ACC_SAT_EN
  , output logic                                o_sat
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_e               state_r;
    state_e               state_next_s;
    logic                 in_ready_s;
    logic                 beat_s;
    logic                 start_s;
    logic                 load_s;
    logic                 err_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_next_s;
    logic [ACC_WIDTH-1:0] lane_res_s [DATA_COPIES];

    // No skid buffer: accept only when the result slot is free or being drained.
    assign in_ready_s = ~o_valid | i_out_ready;
    assign o_in_ready = in_ready_s;

    // Shared beat qualification, start detection and beat counting.
    always_comb begin
        beat_s  = i_valid & in_ready_s;
        start_s = i_first | (state_r == ST_IDLE);
        load_s  = beat_s & i_last;
        err_s   = beat_s & seq_error(state_r, i_first);
        if (start_s) begin
            cnt_next_s = CNT_ONE;
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
        end
    end

    // Next-state: every accepted beat either closes the group or leaves it open.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_ACC: begin
                if (beat_s) begin
                    if (i_last) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_ACC;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Control registers: state, counter, output handshake and sticky error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            o_valid    <= 1'b0;
            o_beat_cnt <= '0;
            o_seq_err  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (beat_s) begin
                cnt_r <= cnt_next_s;
            end
            if (load_s) begin
                o_valid    <= 1'b1;
                o_beat_cnt <= cnt_next_s;
            end else if (i_out_ready) begin
                o_valid <= 1'b0;
            end
            if (err_s) begin
                o_seq_err <= 1'b1;
            end
        end
    end

`ifdef PE_ACC_SAT_EN
    logic lane_sat_s [DATA_COPIES];
    logic any_sat_s;

    // Group-level saturation summary across all lanes.
    always_comb begin
        any_sat_s = 1'b0;
        for (int i = 0; i < DATA_COPIES; i++) begin
            any_sat_s = any_sat_s | lane_sat_s[i];
        end
    end

    // Saturation flag travels with the result it describes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sat <= 1'b0;
        end else if (load_s) begin
            o_sat <= any_sat_s;
        end
    end
`endif

    for (genvar g = 0; g < DATA_COPIES; g++) begin : g_lane
        pe_acc_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_beat     (beat_s),
            .i_start    (start_s),
            .i_load     (load_s),
            .i_product  (i_mul_result[2*DATA_WIDTH*g +: 2*DATA_WIDTH]),
            .o_result   (lane_res_s[g])
`ifdef PE_ACC_SAT_EN
          , .o_sat_next (lane_sat_s[g])
`endif
        );
    end

    // Pack the per-lane result registers onto the flat output bus.
    always_comb begin
        o_acc_result = '0;
        for (int i = 0; i < DATA_COPIES; i++) begin
            o_acc_result[ACC_WIDTH*i +: ACC_WIDTH] = lane_res_s[i];
        end
    end

endmodule

// File: tb/tb_pe_acc.sv
// Directed self-checking bench for pe_acc: a default-size instance plus a
// narrow instance (16-bit accumulators, 4-bit counter) for overflow and wrap cases.
module tb_pe_acc;

    localparam int DW  = 8;
    localparam int DC  = 32;
    localparam int AW  = 32;
    localparam int CW  = 16;
    localparam int DC2 = 2;
    localparam int AW2 = 16;
    localparam int CW2 = 4;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_valid, i_first, i_last, i_out_ready;
    logic [DC*2*DW-1:0] i_mul_result;
    logic              o_in_ready, o_valid, o_seq_err;
    logic [DC*AW-1:0]  o_acc_result;
    logic [CW-1:0]     o_beat_cnt;

    logic              v2, f2, l2, ordy2;
    logic [DC2*2*DW-1:0] mul2;
    logic              rdy2, val2, err2;
    logic [DC2*AW2-1:0] res2;
    logic [CW2-1:0]    cnt2;
`ifdef PE_ACC_SAT_EN
    logic              o_sat, sat2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pe_acc #(.DATA_WIDTH(DW), .DATA_COPIES(DC), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_in_ready(o_in_ready),
        .i_first(i_first), .i_last(i_last), .i_mul_result(i_mul_result),
        .o_valid(o_valid), .i_out_ready(i_out_ready), .o_acc_result(o_acc_result),
        .o_beat_cnt(o_beat_cnt), .o_seq_err(o_seq_err)
`ifdef PE_ACC_SAT_EN
      , .o_sat(o_sat)
`endif
    );

    pe_acc #(.DATA_WIDTH(DW), .DATA_COPIES(DC2), .ACC_WIDTH(AW2), .CNT_WIDTH(CW2)) dut_n (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(v2), .o_in_ready(rdy2),
        .i_first(f2), .i_last(l2), .i_mul_result(mul2),
        .o_valid(val2), .i_out_ready(ordy2), .o_acc_result(res2),
        .o_beat_cnt(cnt2), .o_seq_err(err2)
`ifdef PE_ACC_SAT_EN
      , .o_sat(sat2)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic beat(input logic f, input logic l, input logic [15:0] p0);
        i_valid      = 1'b1;
        i_first      = f;
        i_last       = l;
        i_mul_result = '0;
        i_mul_result[15:0] = p0;
    endtask

    task automatic idle();
        i_valid      = 1'b0;
        i_first      = 1'b0;
        i_last       = 1'b0;
        i_mul_result = '0;
    endtask

    task automatic rst_pulse();
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    logic [15:0] t4_p   [6] = '{16'd10, 16'd20, 16'hFFFF, 16'hFFFE, 16'd1000, 16'd24};
    logic [31:0] t4_sum [3] = '{32'd30, 32'hFFFFFFFD, 32'd1024};

    initial begin
        i_rst_n = 1'b0;
        idle();
        i_out_ready = 1'b1;
        v2 = 1'b0; f2 = 1'b0; l2 = 1'b0; ordy2 = 1'b1; mul2 = '0;
        tick();

        // Reset state
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_lane0", 64'(o_acc_result[31:0]), 64'd0);
        chk("rst_lane31", 64'(o_acc_result[1023:992]), 64'd0);
        chk("rst_cnt", 64'(o_beat_cnt), 64'd0);
        chk("rst_err", 64'(o_seq_err), 64'd0);
        chk("rst_in_ready", 64'(o_in_ready), 64'd1);
        i_rst_n = 1'b1;
        tick();

        // Four-beat group: 3 - 5 + 7 + 100 = 105
        beat(1'b1, 1'b0, 16'd3);    tick();
        chk("t1_valid_b1", 64'(o_valid), 64'd0);
        beat(1'b0, 1'b0, 16'hFFFB); tick();
        beat(1'b0, 1'b0, 16'd7);    tick();
        chk("t1_valid_b3", 64'(o_valid), 64'd0);
        beat(1'b0, 1'b1, 16'd100);  tick();
        idle();
        chk("t1_valid", 64'(o_valid), 64'd1);
        chk("t1_sum", 64'(o_acc_result[31:0]), 64'd105);
        chk("t1_cnt", 64'(o_beat_cnt), 64'd4);
        chk("t1_err", 64'(o_seq_err), 64'd0);
        tick();
        chk("t1_valid_drop", 64'(o_valid), 64'd0);

        // Single-beat group of the most negative product on every lane
        i_valid = 1'b1; i_first = 1'b1; i_last = 1'b1;
        i_mul_result = {DC{16'h8000}};
        tick();
        idle();
        chk("t2_lane0", 64'(o_acc_result[31:0]), 64'hFFFF8000);
        chk("t2_lane17", 64'(o_acc_result[575:544]), 64'hFFFF8000);
        chk("t2_lane31", 64'(o_acc_result[1023:992]), 64'hFFFF8000);
        chk("t2_cnt", 64'(o_beat_cnt), 64'd1);

        // Backpressure: result held, input stalled for five cycles
        i_out_ready = 1'b0;
        beat(1'b1, 1'b1, 16'd5);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_in_ready", 64'(o_in_ready), 64'd0);
            chk("t3_valid", 64'(o_valid), 64'd1);
            chk("t3_lane0", 64'(o_acc_result[31:0]), 64'hFFFF8000);
            chk("t3_cnt", 64'(o_beat_cnt), 64'd1);
            tick();
        end
        i_out_ready = 1'b1;
        #1;
        chk("t3_in_ready_up", 64'(o_in_ready), 64'd1);
        tick();
        idle();
        chk("t3_valid_new", 64'(o_valid), 64'd1);
        chk("t3_lane0_new", 64'(o_acc_result[31:0]), 64'd5);
        chk("t3_lane31_new", 64'(o_acc_result[1023:992]), 64'd0);

        // Back-to-back two-beat groups with the result drained every cycle
        for (int g = 0; g < 3; g++) begin
            beat(1'b1, 1'b0, t4_p[2*g]);
            #1;
            chk("t4_in_ready_a", 64'(o_in_ready), 64'd1);
            tick();
            chk("t4_valid_a", 64'(o_valid), 64'd0);
            beat(1'b0, 1'b1, t4_p[2*g+1]);
            #1;
            chk("t4_in_ready_b", 64'(o_in_ready), 64'd1);
            tick();
            chk("t4_valid_b", 64'(o_valid), 64'd1);
            chk("t4_sum", 64'(o_acc_result[31:0]), 64'(t4_sum[g]));
            chk("t4_cnt", 64'(o_beat_cnt), 64'd2);
        end
        idle();
        tick();
        chk("t4_valid_end", 64'(o_valid), 64'd0);
        chk("t4_err", 64'(o_seq_err), 64'd0);

        // Missing i_first after reset: processed anyway, error flagged
        rst_pulse();
        beat(1'b0, 1'b0, 16'd7); tick();
        chk("t5_err", 64'(o_seq_err), 64'd1);
        beat(1'b0, 1'b1, 16'd8); tick();
        idle();
        chk("t5_valid", 64'(o_valid), 64'd1);
        chk("t5_sum", 64'(o_acc_result[31:0]), 64'd15);
        chk("t5_cnt", 64'(o_beat_cnt), 64'd2);
        chk("t5_err_sticky", 64'(o_seq_err), 64'd1);
        tick();

        // Reset mid-group discards the partial sum
        beat(1'b1, 1'b0, 16'd9); tick();
        idle();
        i_rst_n = 1'b0;
        #1;
        chk("t5r_valid", 64'(o_valid), 64'd0);
        chk("t5r_lane0", 64'(o_acc_result[31:0]), 64'd0);
        chk("t5r_cnt", 64'(o_beat_cnt), 64'd0);
        chk("t5r_err", 64'(o_seq_err), 64'd0);
        tick();
        i_rst_n = 1'b1;
        tick(); tick();
        chk("t5r_no_output", 64'(o_valid), 64'd0);
        beat(1'b0, 1'b1, 16'd4); tick();
        idle();
        chk("t5r_sum", 64'(o_acc_result[31:0]), 64'd4);
        chk("t5r_cnt2", 64'(o_beat_cnt), 64'd1);
        chk("t5r_err2", 64'(o_seq_err), 64'd1);

        // i_first while a partial sum is open: restart and flag
        rst_pulse();
        beat(1'b1, 1'b0, 16'd50); tick();
        chk("t5f_err0", 64'(o_seq_err), 64'd0);
        beat(1'b1, 1'b1, 16'd6); tick();
        idle();
        chk("t5f_sum", 64'(o_acc_result[31:0]), 64'd6);
        chk("t5f_cnt", 64'(o_beat_cnt), 64'd1);
        chk("t5f_err", 64'(o_seq_err), 64'd1);

        // Narrow accumulator overflow: lane0 7FFF+7FFF, lane1 8000+8000
        v2 = 1'b1; f2 = 1'b1; l2 = 1'b0; mul2 = {16'h8000, 16'h7FFF};
        tick();
        f2 = 1'b0; l2 = 1'b1;
        tick();
        v2 = 1'b0; l2 = 1'b0;
        chk("t6_valid", 64'(val2), 64'd1);
        chk("t6_cnt", 64'(cnt2), 64'd2);
`ifdef PE_ACC_SAT_EN
        chk("t6_lane0_sat", 64'(res2[15:0]), 64'h7FFF);
        chk("t6_lane1_sat", 64'(res2[31:16]), 64'h8000);
        chk("t6_osat", 64'(sat2), 64'd1);
`else
        chk("t6_lane0_wrap", 64'(res2[15:0]), 64'hFFFE);
        chk("t6_lane1_wrap", 64'(res2[31:16]), 64'h0000);
`endif

        // 17-beat group: beat counter wraps modulo 16
        mul2 = {16'hFFFF, 16'h0001};
        for (int k = 0; k < 17; k++) begin
            v2 = 1'b1;
            f2 = (k == 0);
            l2 = (k == 16);
            tick();
        end
        v2 = 1'b0; f2 = 1'b0; l2 = 1'b0;
        chk("t6w_valid", 64'(val2), 64'd1);
        chk("t6w_cnt", 64'(cnt2), 64'd1);
        chk("t6w_lane0", 64'(res2[15:0]), 64'h0011);
        chk("t6w_lane1", 64'(res2[31:16]), 64'hFFEF);
        chk("t6w_err", 64'(err2), 64'd0);
`ifdef PE_ACC_SAT_EN
        chk("t6w_osat", 64'(sat2), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
